// File: rtl/countone_udiv_38ns_14ns_24_seq.sv
// Sequential restoring radix-2 unsigned divider, 38b / 14b -> 24b quotient, 14b remainder.
// Inverts the countone 24x14 multiplier; one quotient bit per enabled cycle.
module countone_udiv_38ns_14ns_24_seq #(
    parameter int DIVIDEND_W = 38,
    parameter int DIVISOR_W  = 14,
    parameter int QUOT_W     = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [QUOT_W-1:0]     quot,
    output logic [DIVISOR_W-1:0]  rem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'(QUOT_W - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 ovf_cond;
    logic                 last;
    logic [DIVISOR_W-1:0] div;
    logic [DIVISOR_W-1:0] r;
    logic [QUOT_W-1:0]    s;
    logic [4:0]           cnt;
    logic [DIVISOR_W:0]   t;
    logic                 qbit;
    logic [DIVISOR_W-1:0] r_nxt;

    // Overflow covers both a too-wide quotient and a zero divisor.
    assign ovf_cond = (din0[DIVIDEND_W-1:QUOT_W] >= din1);
    assign last     = (cnt == LAST_STEP);
    assign busy     = (state == CALC);
    assign done     = (state == DONE);

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        t     = {r, s[QUOT_W-1]};
        qbit  = (t >= {1'b0, div});
        r_nxt = t[DIVISOR_W-1:0];
        if (qbit) begin
            r_nxt = t[DIVISOR_W-1:0] - div;
        end
    end

    // Next-state logic; start only accepted from IDLE or DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    accept = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            state_nxt = ovf_cond ? DONE : CALC;
        end
    end

    // State register, frozen while ce is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // Operand latch, iteration registers and held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            div  <= '0;
            r    <= '0;
            s    <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            quot <= '0;
            rem  <= '0;
        end else if (ce) begin
            if (accept) begin
                div <= din1;
                if (ovf_cond) begin
                    ovf  <= 1'b1;
                    quot <= '1;
                    rem  <= '0;
                end else begin
                    ovf <= 1'b0;
                    r   <= din0[DIVIDEND_W-1:QUOT_W];
                    s   <= din0[QUOT_W-1:0];
                    cnt <= '0;
                end
            end else if (state == CALC) begin
                r   <= r_nxt;
                s   <= {s[QUOT_W-2:0], qbit};
                cnt <= cnt + 5'd1;
                if (last) begin
                    quot <= {s[QUOT_W-2:0], qbit};
                    rem  <= r_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_countone_udiv_38ns_14ns_24_seq.sv
// Self-checking bench for countone_udiv_38ns_14ns_24_seq.
// Table vectors, stall/ignore, reset abort and randomized round trips vs arithmetic model.
module tb_countone_udiv_38ns_14ns_24_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [37:0] din0;
    logic [13:0] din1;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [23:0] quot;
    logic [13:0] rem;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [37:0] a;
        logic [13:0] b;
        logic [23:0] q;
        logic [13:0] r;
        bit          o;
        int          lat;
    } vec_t;

    countone_udiv_38ns_14ns_24_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .quot  (quot),
        .rem   (rem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division on the full operands.
    task automatic model(input longint a, input longint b,
                         output longint q, output longint r, output bit o);
        o = (b == 0) || ((a >> 24) >= b);
        if (o) begin
            q = 64'hFFFFFF;
            r = 0;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Present operands with start; returns #1 after the accepting edge.
    task automatic issue(input logic [37:0] a, input logic [13:0] b);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges from the accepting edge until done; optional ce stall
    // window with start pulses of junk operands that must be ignored.
    task automatic wait_done(input int stall_at, input int stall_len,
                             output int lat, output int busy_n, output bit got);
        int n;
        n      = 1;
        busy_n = 0;
        got    = 1'b0;
        lat    = 0;
        while (n < 200 && !got) begin
            if (done) begin
                got = 1'b1;
                lat = n;
            end else begin
                if (busy) busy_n++;
                ce = !(stall_len > 0 && n >= stall_at && n < stall_at + stall_len);
                if (stall_len > 0 &&
                    (n == stall_at + 2 || n == stall_at + stall_len + 1)) begin
                    start = 1'b1;
                    din0  = 38'h0123456789;
                    din1  = 14'd3;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
            end
        end
        ce = 1'b1;
        if (!got) chk("done_timeout", 0, 1);
    endtask

    vec_t   tbl[7];
    int     lat;
    int     bn;
    bit     got;
    longint eq;
    longint er;
    bit     eo;
    logic [23:0] ra;
    logic [13:0] rb;
    longint prod;

    initial begin
        tbl[0] = '{38'd1000, 14'd7, 24'd142, 14'd6, 1'b0, 25};
        tbl[1] = '{38'h3FFEFFFFFF, 14'd16383, 24'd16777215, 14'd16382, 1'b0, 25};
        tbl[2] = '{38'd12345, 14'd0, 24'hFFFFFF, 14'd0, 1'b1, 1};
        tbl[3] = '{38'h0005000000, 14'd5, 24'hFFFFFF, 14'd0, 1'b1, 1};
        tbl[4] = '{38'd0, 14'd1, 24'd0, 14'd0, 1'b0, 25};
        tbl[5] = '{38'h0000FFFFFF, 14'd1, 24'hFFFFFF, 14'd0, 1'b0, 25};
        tbl[6] = '{38'h3FFFFFFFFF, 14'd16383, 24'hFFFFFF, 14'd0, 1'b1, 1};

        ce    = 1'b1;
        start = 1'b1;
        reset = 1'b1;
        din0  = {$urandom, $urandom} % (64'd1 << 38);
        din1  = 14'($urandom);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        @(posedge clk);
        #1;
        chk("rst_no_accept", busy | done, 0);

        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].a, tbl[i].b);
            wait_done(0, 0, lat, bn, got);
            chk($sformatf("t%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("t%0d_busy", i), bn, tbl[i].o ? 0 : 24);
            chk($sformatf("t%0d_quot", i), quot, tbl[i].q);
            chk($sformatf("t%0d_rem", i), rem, tbl[i].r);
            chk($sformatf("t%0d_ovf", i), ovf, tbl[i].o);
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_pulse", i), done, 0);
        end

        issue(38'd123456789, 14'd1000);
        wait_done(5, 10, lat, bn, got);
        chk("stall_lat", lat, 35);
        chk("stall_busy", bn, 34);
        chk("stall_quot", quot, 123456);
        chk("stall_rem", rem, 789);
        chk("stall_ovf", ovf, 0);
        @(posedge clk);
        #1;
        chk("stall_ignored", busy | done, 0);

        for (int i = 0; i < 200; i++) begin
            din0 = {$urandom, $urandom} % (64'd1 << 38);
            if (i % 4 == 0) din0 = din0 >> 14;
            din1 = 14'($urandom);
            model(longint'(din0), longint'(din1), eq, er, eo);
            issue(din0, din1);
            wait_done(0, 0, lat, bn, got);
            chk("rnd_quot", quot, eq);
            chk("rnd_rem", rem, er);
            chk("rnd_ovf", ovf, eo);
            chk("rnd_lat", lat, eo ? 1 : 25);
        end

        issue(38'd999999, 14'd77);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_quot", quot, 0);
        chk("abort_busy", busy, 0);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) got = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", got, 0);

        // Back-to-back: next start presented in the DONE cycle.
        ra = 24'($urandom);
        rb = 14'($urandom_range(1, 16383));
        issue(38'(longint'(ra) * longint'(rb)), rb);
        for (int i = 0; i < 1000; i++) begin
            wait_done(0, 0, lat, bn, got);
            prod = longint'(ra) * longint'(rb);
            model(prod, longint'(rb), eq, er, eo);
            chk("rt_quot", quot, ra);
            chk("rt_rem", rem, er);
            chk("rt_ovf", ovf, eo);
            chk("rt_lat", lat, 25);
            if (i < 999) begin
                ra = 24'($urandom);
                rb = 14'($urandom_range(1, 16383));
                issue(38'(longint'(ra) * longint'(rb)), rb);
                chk("rt_no_bubble", busy, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/countone_udiv_38ns_14ns_24_seq.md
# countone_udiv_38ns_14ns_24_seq

Sequential unsigned divider that inverts the 24×14→38 multiplier used in the countone datapath. It takes a 38-bit dividend and a 14-bit divisor and returns a 24-bit quotient and a 14-bit remainder. It uses a restoring radix-2 algorithm that resolves one quotient bit per enabled cycle. It runs on the same `clk`/`reset`/`ce` domain as the multiplier, so scaled counts can be converted back to per-unit values.

## Interface
- `DIVIDEND_W`, 38, dividend width (fixed; other values unsupported)
- `DIVISOR_W`, 14, divisor and remainder width (fixed)
- `QUOT_W`, 24, quotient width (fixed; equals `DIVIDEND_W - DIVISOR_W`)
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ce`  in  1  clock enable; when low, all state, counters and outputs hold
- `start`  in  1  request; sampled only when `ce`=1 and state is IDLE or DONE
- `din0`  in  38  dividend, sampled with `start`
- `din1`  in  14  divisor, sampled with `start`
- `busy`  out  1  high while in CALC
- `done`  out  1  one-cycle pulse; result valid
- `ovf`  out  1  result overflow or divide-by-zero, qualified by `done`, held with result
- `quot`  out  24  quotient, held until next accepted start
- `rem`  out  14  remainder, held until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- Reset forces state IDLE. It also clears `busy`, `done`, `ovf`, `quot`, `rem` and the bit counter.
- Accept: when `ce`=1 and `start`=1 in IDLE or DONE, the block latches `din0`/`din1`.
  - `start` in CALC is ignored, with no queuing.
  - In DONE without `start`, the block returns to IDLE.
- Overflow check at accept: `ovf_cond = (din0[37:24] >= din1)`. This covers both a quotient that does not fit in 24 bits and `din1`=0.
  - If `ovf_cond`, go directly to DONE with `ovf`=1, `quot`=24'hFFFFFF, `rem`=0.
  - Otherwise go to CALC with `ovf`=0, partial remainder R=`din0[37:24]`, shift register S=`din0[23:0]`, counter=0.
- CALC step (each enabled cycle):
  - T = {R, S[23]} (15 bits).
  - If T ≥ divisor: R ← T − divisor and qbit=1. Otherwise R ← T[13:0] and qbit=0.
  - S ← {S[22:0], qbit}.
  - Counter increments.
  - R is always < divisor, so 14 bits suffice.
- After the 24th step (counter=23 at the edge), the block loads `quot`←final S and `rem`←final R, then enters DONE.
- Invariant when `ovf`=0: `din0 = quot*din1 + rem` and `rem < din1`.
- The `quot`/`rem` outputs change only at DONE entry and at reset. Intermediate S and R are internal.

## Timing
- Let edge k be the enabled edge that accepts `start`.
- Normal path:
  - `busy`=1 from after edge k until after edge k+24.
  - `done`=1 for exactly one cycle, following edge k+24. Latency is 25 enabled cycles.
- Overflow path: `done`=1 in the cycle after edge k. Latency is 1, and `busy` stays 0.
- `ce`=0 cycles stretch every latency one-for-one. While `ce`=0, `done` holds its current value.
- Back-to-back: `start` in the DONE cycle is accepted. The next CALC begins immediately, with no IDLE bubble.
- Reset mid-CALC aborts the operation. Outputs return to their reset values on the next edge and no `done` is produced.
- Reset has priority over `start` and `ce`.

## Test plan
- Reset: assert `reset` for 2 cycles with random inputs. Require `busy`=`done`=`ovf`=0 and `quot`=`rem`=0. A `start` during reset is not accepted.
- Basic: `din0`=1000, `din1`=7, `ce`=1. Require `done` exactly 25 cycles after the start edge, `quot`=142, `rem`=6, `ovf`=0, and `busy` high for 24 cycles.
- Max-fit: `din0`=16383·2^24−1, `din1`=16383. Require `quot`=16777215, `rem`=16382, `ovf`=0.
- Overflow:
  - `din1`=0 with any `din0`: `done` 1 cycle after start, `ovf`=1, `quot`=24'hFFFFFF, `rem`=0.
  - `din0`=5·2^24, `din1`=5: same response.
- Stall and ignore: drop `ce` for 10 cycles mid-CALC and pulse `start` with new operands while `busy`. Require `done` at 35 cycles after the start edge, the original operands' result, and the second `start` ignored.
- Round trip: feed 1,000 random products `a·b` (a<2^24, 1≤b<2^14) from the multiplier, issued back-to-back via start-in-DONE. Require `quot`=a, `rem`=0, `ovf`=0 for every result. Also apply reset mid-CALC once and require no `done` pulse.
